operand_pair_sequencer: RTL and testbench
=========================================

Name: operand_pair_sequencer

Overview:
- Consumer side of the 8-wide operand matcher.
- Accepts one packed match-result word per handshake and serializes it into one (activation index, weight index) pair per cycle for the PE operand-fetch stage.
- Handles empty results and back-pressure, and overlaps loading of the next word with the hand-off of the last pair, so there are no bubbles between words.

Parameters:
- BITMASK_LENGTH, 8: maximum pairs per word; bitmask lanes upstream.
- INDEX_BITWIDTH, 3: width of each dense index field.
- BITWIDTH_COUNT, 4: width of the pair-count field.
- RESULT_WIDTH, 64: width of the packed result word.

Ports:
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- ivalid  in  1  upstream result word valid.
- oready  out  1  sequencer can accept a word this cycle.
- result  in  RESULT_WIDTH  packed word, fields as follows:
  - [23:0] activation indices, slot k at [3k+2:3k].
  - [47:24] weight indices, same slot layout.
  - [51:48] pair count.
  - [63:52] ignored.
- ovalid  out  1  pair output valid.
- iready  in  1  downstream accepts pair.
- idxA  out  INDEX_BITWIDTH  activation dense index of current pair.
- idxW  out  INDEX_BITWIDTH  weight dense index of current pair.
- pairPos  out  INDEX_BITWIDTH  slot number k of current pair.
- last  out  1  current pair is the final pair of its word.
- busy  out  1  a word is held (state EMIT).

Behaviour:
- One clock, `clock`. Reset is asynchronous and active-low on `resetn`.
- Reset values: state=IDLE; held word=0; ptr=0; cnt=0. Outputs: ovalid=0, last=0, busy=0, idxA=idxW=pairPos=0; oready=1 once resetn deasserts.
- Storage registers:
  - held activation field (24b), held weight field (24b);
  - cnt (BITWIDTH_COUNT);
  - ptr (INDEX_BITWIDTH), the current slot.
- Output derivation:
  - idxA/idxW = slot ptr of the held fields; pairPos = ptr.
  - last = (ptr == cnt-1) in EMIT, else 0.
  - All outputs are decoded from registers only; no combinational path from result/ivalid to outputs.
- Count clamp: an incoming count > BITMASK_LENGTH is clamped to BITMASK_LENGTH at load.
- Handshakes:
  - accept = ivalid & oready; give = ovalid & iready.
  - oready = (state==IDLE) | (give & last). This is the only input-to-output combinational path (iready→oready).
- State IDLE (ovalid=0):
  - On accept with count==0: word consumed, no pair emitted, remain IDLE.
  - On accept with count>0: load fields, cnt=count, ptr=0, go to EMIT.
- State EMIT (ovalid=1):
  - give & !last: ptr+1.
  - give & last & accept with count>0: load new word, ptr=0, stay EMIT (zero-bubble back-to-back).
  - give & last & accept with count==0: go to IDLE.
  - give & last & !accept: go to IDLE.
  - !give: hold all registers; idxA/idxW/pairPos/last stable (AXI-style, ovalid never drops without give).
- Latency: accept to first ovalid is 1 cycle. A word with N pairs occupies exactly N give cycles.
- Reset mid-EMIT: pending pairs are discarded and outputs return to reset values asynchronously. The upstream word in flight is not consumed.
- ptr never exceeds cnt-1, so no wrap-around occurs; no wrap is needed with INDEX_BITWIDTH=3 and cnt≤8.

Decomposition:
- Shared package holds:
  - BITMASK_LENGTH, INDEX_BITWIDTH, BITWIDTH_COUNT;
  - field offsets ACT_LSB=0, WGT_LSB=24, CNT_LSB=48;
  - state enum {IDLE, EMIT}.
- The matcher and this block both import these offsets.
- One sub-module, `index_slot_mux` (INDEX_BITWIDTH×BITMASK_LENGTH packed field + ptr → index), instantiated twice (activation, weight).

Test Plan:
- bitmaskA=8'b1011_0110, bitmaskW=8'b1101_0100 → result=64'h0003_0000_C800_0111, iready=1 → three cycles (idxA,idxW,pairPos,last) = (1,0,0,0), (2,1,1,0), (4,3,2,1); oready high in cycle 3.
- Count=0 word (64'h0) → consumed in one cycle; ovalid stays 0; oready remains 1.
- Same word as scenario 1 with iready held low for 4 cycles after first ovalid → outputs frozen at (1,0,0,0), then resume; exactly 3 gives total.
- Two back-to-back words, count=2 then count=8 (slots 0..7 = 0..7 for both fields) → 10 consecutive give cycles with no ovalid gap; last asserted on pair 2 and pair 10.
- Count field 4'hF with full slots → clamped: exactly 8 pairs emitted, last on pairPos=7.
- resetn pulsed low asynchronously mid-word (after pair 1 of 3) → ovalid=0 immediately; after release, busy=0 and next accepted word starts at pairPos=0.

Source files
------------

// File: rtl/operand_pair_sequencer_pkg.sv
// Shared constants, field offsets and state encoding for the operand matcher and sequencer.
package operand_pair_sequencer_pkg;

   localparam int unsigned BITMASK_LENGTH = 8;
   localparam int unsigned INDEX_BITWIDTH = 3;
   localparam int unsigned BITWIDTH_COUNT = 4;
   localparam int unsigned RESULT_WIDTH   = 64;
   localparam int unsigned FIELD_WIDTH    = INDEX_BITWIDTH * BITMASK_LENGTH;

   localparam int unsigned ACT_LSB = 0;
   localparam int unsigned WGT_LSB = 24;
   localparam int unsigned CNT_LSB = 48;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Limit an incoming pair count to the number of bitmask lanes.
   function automatic logic [BITWIDTH_COUNT-1:0] clamp_count(input logic [BITWIDTH_COUNT-1:0] c);
      return (c > BITWIDTH_COUNT'(BITMASK_LENGTH)) ? BITWIDTH_COUNT'(BITMASK_LENGTH) : c;
   endfunction

endpackage

// File: rtl/operand_pair_sequencer_index_slot_mux.sv
// Selects one INDEX_BITWIDTH slot out of a packed index field.
module index_slot_mux
   import operand_pair_sequencer_pkg::*;
(
   input  logic [FIELD_WIDTH-1:0]    i_field,
   input  logic [INDEX_BITWIDTH-1:0] i_sel,
   output logic [INDEX_BITWIDTH-1:0] o_idx_c
);

   // One-hot compare against every slot number.
   always_comb begin
      o_idx_c = '0;
      for (int k = 0; k < BITMASK_LENGTH; k++) begin
         if (i_sel == INDEX_BITWIDTH'(k)) begin
            o_idx_c = i_field[k*INDEX_BITWIDTH +: INDEX_BITWIDTH];
         end
      end
   end

endmodule

// File: rtl/operand_pair_sequencer.sv
// Serializes one packed match-result word into (activation, weight) index pairs, one per cycle.
module operand_pair_sequencer
   import operand_pair_sequencer_pkg::*;
(
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      ivalid,
   output logic                      oready,
   input  logic [RESULT_WIDTH-1:0]   result,
   output logic                      ovalid,
   input  logic                      iready,
   output logic [INDEX_BITWIDTH-1:0] idxA,
   output logic [INDEX_BITWIDTH-1:0] idxW,
   output logic [INDEX_BITWIDTH-1:0] pairPos,
   output logic                      last,
   output logic                      busy
);

   state_t                    r_state, w_state_nxt;
   logic [FIELD_WIDTH-1:0]    r_act, w_act_nxt;
   logic [FIELD_WIDTH-1:0]    r_wgt, w_wgt_nxt;
   logic [BITWIDTH_COUNT-1:0] r_cnt, w_cnt_nxt;
   logic [INDEX_BITWIDTH-1:0] r_ptr, w_ptr_nxt;

   logic                      w_emit;
   logic                      w_last;
   logic                      w_give;
   logic                      w_accept;
   logic [BITWIDTH_COUNT-1:0] w_cnt_in;
   logic                      w_unused_bits;

   assign w_cnt_in      = clamp_count(result[CNT_LSB +: BITWIDTH_COUNT]);
   assign w_unused_bits = ^result[RESULT_WIDTH-1:CNT_LSB+BITWIDTH_COUNT];

   // Handshake and output decode, all from registers except iready -> oready.
   assign w_emit   = (r_state == EMIT);
   assign w_last   = w_emit && (BITWIDTH_COUNT'(r_ptr) == (r_cnt - BITWIDTH_COUNT'(1)));
   assign w_give   = w_emit && iready;
   assign w_accept = ivalid && oready;

   assign oready  = (r_state == IDLE) || (w_give && w_last);
   assign ovalid  = w_emit;
   assign busy    = w_emit;
   assign last    = w_last;
   assign pairPos = r_ptr;

   // Next-state: load on accept, step ptr on give, reload on the last give for zero bubbles.
   always_comb begin
      w_state_nxt = r_state;
      w_act_nxt   = r_act;
      w_wgt_nxt   = r_wgt;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (w_accept && (w_cnt_in != '0)) begin
               w_state_nxt = EMIT;
               w_act_nxt   = result[ACT_LSB +: FIELD_WIDTH];
               w_wgt_nxt   = result[WGT_LSB +: FIELD_WIDTH];
               w_cnt_nxt   = w_cnt_in;
               w_ptr_nxt   = '0;
            end
         end
         EMIT: begin
            if (w_give) begin
               if (!w_last) begin
                  w_ptr_nxt = r_ptr + INDEX_BITWIDTH'(1);
               end else if (w_accept && (w_cnt_in != '0)) begin
                  w_act_nxt = result[ACT_LSB +: FIELD_WIDTH];
                  w_wgt_nxt = result[WGT_LSB +: FIELD_WIDTH];
                  w_cnt_nxt = w_cnt_in;
                  w_ptr_nxt = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and held-word registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_act   <= '0;
         r_wgt   <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_act   <= w_act_nxt;
         r_wgt   <= w_wgt_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   index_slot_mux u_act_mux (
      .i_field (r_act),
      .i_sel   (r_ptr),
      .o_idx_c (idxA)
   );

   index_slot_mux u_wgt_mux (
      .i_field (r_wgt),
      .i_sel   (r_ptr),
      .o_idx_c (idxW)
   );

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Directed bench for operand_pair_sequencer with hand-computed expected pairs.
module tb_operand_pair_sequencer;

   logic        clock = 1'b0;
   logic        resetn;
   logic        ivalid;
   logic        oready;
   logic [63:0] result;
   logic        ovalid;
   logic        iready;
   logic [2:0]  idxA;
   logic [2:0]  idxW;
   logic [2:0]  pairPos;
   logic        last;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int gives  = 0;
   int g0;

   localparam logic [63:0] W1     = 64'h0003_0000_C800_0111;
   localparam logic [23:0] SEQ    = 24'hFAC688;   // slot k holds k
   localparam logic [63:0] W_CNT2 = {12'h0, 4'h2, SEQ, SEQ};
   localparam logic [63:0] W_CNT8 = {12'h0, 4'h8, SEQ, SEQ};
   localparam logic [63:0] W_CNTF = {12'h0, 4'hF, SEQ, SEQ};

   always #5 clock = ~clock;

   operand_pair_sequencer dut (
      .clock   (clock),
      .resetn  (resetn),
      .ivalid  (ivalid),
      .oready  (oready),
      .result  (result),
      .ovalid  (ovalid),
      .iready  (iready),
      .idxA    (idxA),
      .idxW    (idxW),
      .pairPos (pairPos),
      .last    (last),
      .busy    (busy)
   );

   // Count completed pair handoffs.
   always @(posedge clock) begin
      if (ovalid && iready) gives++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pair(input string tag, input int a, input int w, input int p, input int l);
      chk({tag, "_ovalid"}, 8'(ovalid), 8'd1);
      chk({tag, "_idxA"},   8'(idxA),   8'(a));
      chk({tag, "_idxW"},   8'(idxW),   8'(w));
      chk({tag, "_pos"},    8'(pairPos), 8'(p));
      chk({tag, "_last"},   8'(last),   8'(l));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ovalid"}, 8'(ovalid), 8'd0);
      chk({tag, "_busy"},   8'(busy),   8'd0);
      chk({tag, "_last"},   8'(last),   8'd0);
      chk({tag, "_oready"}, 8'(oready), 8'd1);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn = 1'b1;
      ivalid = 1'b0;
      iready = 1'b0;
      result = '0;
      #2 resetn = 1'b0;
      #20;
      chk("rst_ovalid", 8'(ovalid), 8'd0);
      chk("rst_busy",   8'(busy),   8'd0);
      chk("rst_last",   8'(last),   8'd0);
      chk("rst_idxA",   8'(idxA),   8'd0);
      chk("rst_idxW",   8'(idxW),   8'd0);
      chk("rst_pos",    8'(pairPos), 8'd0);
      resetn = 1'b1;
      step();
      chk("rst_oready", 8'(oready), 8'd1);

      // Three-pair word with continuous ready.
      result = W1; ivalid = 1'b1; iready = 1'b1;
      g0 = gives;
      step(); ivalid = 1'b0; #1;
      chk_pair("s1_p0", 1, 0, 0, 0);
      chk("s1_p0_oready", 8'(oready), 8'd0);
      step(); chk_pair("s1_p1", 2, 1, 1, 0);
      step(); chk_pair("s1_p2", 4, 3, 2, 1);
      chk("s1_p2_oready", 8'(oready), 8'd1);
      step(); chk_idle("s1_end");
      chk("s1_gives", 8'(gives - g0), 8'd3);

      // Empty word is swallowed without output.
      result = 64'h0; ivalid = 1'b1;
      #1 chk("s2_oready_pre", 8'(oready), 8'd1);
      step(); ivalid = 1'b0; #1;
      chk_idle("s2_after");
      step(); chk_idle("s2_after2");

      // Back-pressure freezes the first pair.
      result = W1; ivalid = 1'b1; iready = 1'b0;
      g0 = gives;
      step(); ivalid = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         chk_pair("s3_hold", 1, 0, 0, 0);
         chk("s3_hold_oready", 8'(oready), 8'd0);
         step();
      end
      iready = 1'b1; #1;
      chk_pair("s3_p0", 1, 0, 0, 0);
      step(); chk_pair("s3_p1", 2, 1, 1, 0);
      step(); chk_pair("s3_p2", 4, 3, 2, 1);
      step(); chk_idle("s3_end");
      chk("s3_gives", 8'(gives - g0), 8'd3);

      // Back-to-back words of 2 then 8 pairs without a bubble.
      result = W_CNT2; ivalid = 1'b1;
      g0 = gives;
      step(); result = W_CNT8; #1;
      chk_pair("s4_a0", 0, 0, 0, 0);
      chk("s4_a0_oready", 8'(oready), 8'd0);
      step(); chk_pair("s4_a1", 1, 1, 1, 1);
      chk("s4_a1_oready", 8'(oready), 8'd1);
      step(); ivalid = 1'b0; #1;
      for (int k = 0; k < 8; k++) begin
         chk_pair("s4_b", k, k, k, (k == 7) ? 1 : 0);
         step();
      end
      chk_idle("s4_end");
      chk("s4_gives", 8'(gives - g0), 8'd10);

      // Oversized count is clamped to eight pairs.
      result = W_CNTF; ivalid = 1'b1;
      g0 = gives;
      step(); ivalid = 1'b0; #1;
      for (int k = 0; k < 8; k++) begin
         chk_pair("s5", k, k, k, (k == 7) ? 1 : 0);
         step();
      end
      chk_idle("s5_end");
      chk("s5_gives", 8'(gives - g0), 8'd8);

      // Asynchronous reset in the middle of a word.
      result = W1; ivalid = 1'b1;
      step(); ivalid = 1'b0; #1;
      chk_pair("s6_p0", 1, 0, 0, 0);
      step(); chk_pair("s6_p1", 2, 1, 1, 0);
      result = W_CNT8; ivalid = 1'b1;
      #1 resetn = 1'b0;
      #1;
      chk("s6_rst_ovalid", 8'(ovalid), 8'd0);
      chk("s6_rst_busy",   8'(busy),   8'd0);
      chk("s6_rst_last",   8'(last),   8'd0);
      chk("s6_rst_pos",    8'(pairPos), 8'd0);
      chk("s6_rst_idxA",   8'(idxA),   8'd0);
      ivalid = 1'b0;
      #2 resetn = 1'b1;
      step();
      chk_idle("s6_post");
      result = W1; ivalid = 1'b1;
      step(); ivalid = 1'b0; #1;
      chk_pair("s6_n0", 1, 0, 0, 0);
      step(); chk_pair("s6_n1", 2, 1, 1, 0);
      step(); chk_pair("s6_n2", 4, 3, 2, 1);
      step(); chk_idle("s6_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
